// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared reset PC, buffer depth and FSM encoding for the fetch unit
package ifetch_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry in-order instruction/PC FIFO with flush
module fetch_buf (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        push_i,
    input  logic [31:0] push_instr_i,
    input  logic [31:0] push_pc_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [1:0]  count_o,
    output logic [31:0] head_instr_o,
    output logic [31:0] head_pc_o
);

    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_q[0] <= 32'h0;
            instr_q[1] <= 32'h0;
            pc_q[0]    <= 32'h0;
            pc_q[1]    <= 32'h0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                instr_q[wr_ptr_q] <= push_instr_i;
                pc_q[wr_ptr_q]    <= push_pc_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = instr_q[rd_ptr_q];
    assign head_pc_o    = pc_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: single-outstanding memory requests feeding a two-entry buffer
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam logic [31:0] START_PC = align_pc(RESET_PC);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] req_pc_q;
    logic [31:0] req_pc_d;
    logic        discard_q;
    logic        discard_d;
    logic        buf_push;
    logic        buf_pop;
    logic [1:0]  buf_count;

    assign instr_valid_o = (buf_count != 2'd0);
    assign buf_pop       = instr_valid_o && instr_ready_i && !redirect_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_RESET;
            fetch_pc_q <= START_PC;
            req_pc_q   <= START_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        mem_req_o  = 1'b0;
        mem_addr_o = fetch_pc_q;
        buf_push   = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_REQ;
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    discard_d = 1'b0;
                    buf_push  = !discard_q;
                    if (!discard_q && ((buf_count + 2'd1 - 2'(buf_pop)) == 2'(BUF_DEPTH))) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FULL: begin
                if (buf_pop) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // A redirect wins over everything; if a response is still owed we wait it out and drop it.
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
            buf_push   = 1'b0;
            if ((state_q == ST_WAIT && !mem_rvalid_i) || (state_q == ST_REQ && mem_gnt_i)) begin
                state_d   = ST_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = ST_REQ;
                discard_d = 1'b0;
            end
        end
    end

    fetch_buf u_buf (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .push_i       (buf_push),
        .push_instr_i (mem_rdata_i),
        .push_pc_i    (req_pc_q),
        .pop_i        (buf_pop),
        .flush_i      (redirect_i),
        .count_o      (buf_count),
        .head_instr_o (instr_o),
        .head_pc_o    (instr_pc_o)
    );

endmodule
